if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  LC-3b IF stage; sits directly upstream of the IF/ID state register.
//  Owns the fetch PC and runs the I-cache read handshake. Predicts next PC via a
//  direct-mapped BTB with 2-bit counters; per delivered instruction it presents
//  PC, IR, prediction, BTB target and fall-through PC, plus load/stall controls.
// PARAMETERS
//  BTB_IDX_BITS  3        BTB entries = 2**BTB_IDX_BITS; index = pc[BTB_IDX_BITS:1]
//  RESET_PC      16'h0000 fetch PC after reset
// PORTS
//  clk                   in   1   clock, all state on rising edge
//  rst_n                 in   1   asynchronous, active-low reset
//  pipe_stall            in   1   downstream cannot accept (IF/ID must hold)
//  redirect_valid        in   1   mispredict/flush; refetch from redirect_pc
//  redirect_pc           in   16  corrected PC
//  btb_upd_valid         in   1   resolved control-flow instruction from EX/MEM
//  btb_upd_pc            in   16  PC of resolved instruction
//  btb_upd_target        in   16  resolved target
//  btb_upd_taken         in   1   resolved direction
//  icache_read           out  1   read request, held until icache_resp
//  icache_addr           out  16  request address, stable while icache_read=1
//  icache_resp           in   1   1-cycle pulse: icache_rdata valid
//  icache_rdata          in   16  fetched instruction word
//  load_if_id            out  1   IF/ID captures this cycle
//  i_cache_stall         out  1   no valid instruction presented (IF/ID zeroes input)
//  if_pc_out             out  16  PC of presented instruction
//  if_ir_out             out  16  presented instruction word
//  if_pred_taken_out     out  1   predicted taken (BTB hit & counter[1])
//  if_btb_hit_out        out  1   BTB hit
//  if_btb_target_out     out  16  BTB target; 16'h0 on miss
//  if_flush_pc_out       out  16  fall-through PC = if_pc_out + 2
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, fetch_pc=RESET_PC, all BTB valid=0,
//   icache_read=0, load_if_id=0, i_cache_stall=1, all data outputs 0.
//   icache_read first asserts the cycle after rst_n deasserts.
//  States:
//   FETCH: icache_read=1, icache_addr=fetch_pc.
//    resp & redirect       -> discard rdata, fetch_pc<=redirect_pc, stay FETCH.
//    resp & ~pipe_stall    -> present rdata (same cycle, combinational), load_if_id=1,
//                             fetch_pc<=next_pc, stay FETCH (new request next cycle).
//    resp & pipe_stall     -> hold_ir<=rdata, hold_pc<=fetch_pc, go HOLD.
//    ~resp & redirect      -> drop_addr<=fetch_pc, fetch_pc<=redirect_pc, go DROP.
//   HOLD: icache_read=0; presents hold_ir/hold_pc; load_if_id=~pipe_stall.
//    redirect              -> discard, fetch_pc<=redirect_pc, go FETCH (priority).
//    ~pipe_stall           -> fetch_pc<=next_pc(hold_pc), go FETCH.
//   DROP: icache_read=1, icache_addr=drop_addr (in-flight read completes unchanged);
//    resp -> discard, go FETCH. redirect here updates fetch_pc only.
//  redirect_valid has priority over every other event; never loads IF/ID that cycle.
//  i_cache_stall = ~(instruction presented); load_if_id=0 whenever i_cache_stall=1.
//  Prediction (combinational on presented PC p): idx=p[BTB_IDX_BITS:1],
//   hit=valid[idx] & tag[idx]==p[15:BTB_IDX_BITS+1]; taken=hit & ctr[idx][1];
//   next_pc = taken ? target[idx] : p+2 (16-bit wrap: 16'hFFFE+2=16'h0000).
//  BTB update on btb_upd_valid (registered, visible next cycle; same-cycle lookup
//   of the same index sees old contents):
//   tag match & valid -> target<=upd_target; ctr saturating +1 if taken else -1.
//   else allocate     -> valid=1, tag, target; ctr = taken ? 2'b10 : 2'b01.
//  No PC alignment check; bit 0 of all PCs is propagated unchanged.
// TESTING
//  1 Reset mid-FETCH (icache_read=1) -> next cycle icache_read=0, all outputs 0;
//    after release, icache_addr=RESET_PC=16'h0000.
//  2 Straight-line, 1-cycle cache latency, no BTB hits -> if_pc_out 0,2,4,6;
//    if_flush_pc_out 2,4,6,8; load_if_id pulses on each resp.
//  3 resp with pipe_stall=1 for 3 cycles -> HOLD keeps IR/PC stable, load_if_id=0;
//    on release single load, next icache_addr=PC+2, no request issued while held.
//  4 redirect_valid (pc=16'h0040) while read to 16'h0010 pending -> icache_addr stays
//    16'h0010 until resp, that word never loaded; next request addr=16'h0040.
//  5 BTB update pc=16'h0008 target=16'h0020 taken twice -> next fetch of 16'h0008:
//    hit=1, taken=1, target=16'h0020, following icache_addr=16'h0020.
//  6 Counter saturation: 3 taken then 1 not-taken on same PC -> still predicted
//    taken (ctr 11->10); second not-taken -> predicted not-taken (01), hit=1.

Source files
------------

// File: rtl/if_fetch_unit.sv
// LC-3b instruction fetch stage: owns the fetch PC, runs the I-cache read handshake,
// and predicts the next PC with a direct-mapped BTB of 2-bit saturating counters.
`default_nettype none

module if_fetch_unit #(
    parameter int          BTB_IDX_BITS = 3,
    parameter logic [15:0] RESET_PC     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        btb_upd_valid,
    input  logic [15:0] btb_upd_pc,
    input  logic [15:0] btb_upd_target,
    input  logic        btb_upd_taken,
    output logic        icache_read,
    output logic [15:0] icache_addr,
    input  logic        icache_resp,
    input  logic [15:0] icache_rdata,
    output logic        load_if_id,
    output logic        i_cache_stall,
    output logic [15:0] if_pc_out,
    output logic [15:0] if_ir_out,
    output logic        if_pred_taken_out,
    output logic        if_btb_hit_out,
    output logic [15:0] if_btb_target_out,
    output logic [15:0] if_flush_pc_out
);

    localparam int ENTRIES = 1 << BTB_IDX_BITS;
    localparam int TAG_W   = 16 - BTB_IDX_BITS - 1;

    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DROP = 2'd2} state_t;

    state_t      state, state_next;
    logic        active;
    logic [15:0] fetch_pc, fetch_pc_next;
    logic [15:0] hold_pc, hold_ir, drop_addr;
    logic        take_hold, take_drop;

    logic        presented;
    logic [15:0] pres_pc, pres_ir;

    logic                    btb_valid  [ENTRIES];
    logic [TAG_W-1:0]        btb_tag    [ENTRIES];
    logic [15:0]             btb_target [ENTRIES];
    logic [1:0]              btb_ctr    [ENTRIES];

    logic [BTB_IDX_BITS-1:0] look_idx;
    logic                    look_hit, look_taken;
    logic [15:0]             pc_plus2, next_pc;

    logic [BTB_IDX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]        upd_tag;
    logic                    upd_hit;
    logic                    unused_upd_bit0;

    // Which instruction (if any) is offered to IF/ID this cycle.
    always_comb begin
        presented = 1'b0;
        pres_pc   = 16'h0000;
        pres_ir   = 16'h0000;
        if (active && !redirect_valid) begin
            if (state == FETCH && icache_resp) begin
                presented = 1'b1;
                pres_pc   = fetch_pc;
                pres_ir   = icache_rdata;
            end else if (state == HOLD) begin
                presented = 1'b1;
                pres_pc   = hold_pc;
                pres_ir   = hold_ir;
            end
        end
    end

    assign look_idx   = pres_pc[BTB_IDX_BITS:1];
    assign look_hit   = presented && btb_valid[look_idx]
                        && (btb_tag[look_idx] == pres_pc[15:BTB_IDX_BITS+1]);
    assign look_taken = look_hit && btb_ctr[look_idx][1];
    assign pc_plus2   = pres_pc + 16'd2;
    assign next_pc    = look_taken ? btb_target[look_idx] : pc_plus2;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        take_hold     = 1'b0;
        take_drop     = 1'b0;
        load_if_id    = 1'b0;
        icache_read   = 1'b0;
        icache_addr   = 16'h0000;
        if (!active) begin
            if (redirect_valid) fetch_pc_next = redirect_pc;
        end else begin
            case (state)
                FETCH: begin
                    icache_read = 1'b1;
                    icache_addr = fetch_pc;
                    if (redirect_valid) begin
                        fetch_pc_next = redirect_pc;
                        if (!icache_resp) begin
                            take_drop  = 1'b1;
                            state_next = DROP;
                        end
                    end else if (icache_resp) begin
                        if (!pipe_stall) begin
                            load_if_id    = 1'b1;
                            fetch_pc_next = next_pc;
                        end else begin
                            take_hold  = 1'b1;
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        fetch_pc_next = redirect_pc;
                        state_next    = FETCH;
                    end else if (!pipe_stall) begin
                        load_if_id    = 1'b1;
                        fetch_pc_next = next_pc;
                        state_next    = FETCH;
                    end
                end
                DROP: begin
                    // The stale read must finish at its original address.
                    icache_read = 1'b1;
                    icache_addr = drop_addr;
                    if (redirect_valid) fetch_pc_next = redirect_pc;
                    if (icache_resp)    state_next    = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            active    <= 1'b0;
            fetch_pc  <= RESET_PC;
            hold_pc   <= 16'h0000;
            hold_ir   <= 16'h0000;
            drop_addr <= 16'h0000;
        end else begin
            state    <= state_next;
            active   <= 1'b1;
            fetch_pc <= fetch_pc_next;
            if (take_hold) begin
                hold_pc <= fetch_pc;
                hold_ir <= icache_rdata;
            end
            if (take_drop) drop_addr <= fetch_pc;
        end
    end

    assign upd_idx         = btb_upd_pc[BTB_IDX_BITS:1];
    assign upd_tag         = btb_upd_pc[15:BTB_IDX_BITS+1];
    assign upd_hit         = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    assign unused_upd_bit0 = btb_upd_pc[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) btb_valid[i] <= 1'b0;
        end else if (btb_upd_valid) begin
            btb_valid[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_upd_valid) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= btb_upd_target;
            if (upd_hit) begin
                if (btb_upd_taken)
                    btb_ctr[upd_idx] <= (btb_ctr[upd_idx] == 2'b11) ? 2'b11 : btb_ctr[upd_idx] + 2'd1;
                else
                    btb_ctr[upd_idx] <= (btb_ctr[upd_idx] == 2'b00) ? 2'b00 : btb_ctr[upd_idx] - 2'd1;
            end else begin
                btb_ctr[upd_idx] <= btb_upd_taken ? 2'b10 : 2'b01;
            end
        end
    end

    assign i_cache_stall     = !presented;
    assign if_pc_out         = pres_pc;
    assign if_ir_out         = pres_ir;
    assign if_pred_taken_out = look_taken;
    assign if_btb_hit_out    = look_hit;
    assign if_btb_target_out = look_hit ? btb_target[look_idx] : 16'h0000;
    assign if_flush_pc_out   = presented ? pc_plus2 : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
`default_nettype none

module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_stall, redirect_valid, btb_upd_valid, btb_upd_taken;
    logic [15:0] redirect_pc, btb_upd_pc, btb_upd_target;
    logic        icache_read, icache_resp, load_if_id, i_cache_stall;
    logic [15:0] icache_addr, icache_rdata;
    logic        if_pred_taken_out, if_btb_hit_out;
    logic [15:0] if_pc_out, if_ir_out, if_btb_target_out, if_flush_pc_out;

    int tests = 0;
    int fails = 0;

    if_fetch_unit #(.BTB_IDX_BITS(3), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
        .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
        .icache_read(icache_read), .icache_addr(icache_addr),
        .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .load_if_id(load_if_id), .i_cache_stall(i_cache_stall),
        .if_pc_out(if_pc_out), .if_ir_out(if_ir_out),
        .if_pred_taken_out(if_pred_taken_out), .if_btb_hit_out(if_btb_hit_out),
        .if_btb_target_out(if_btb_target_out), .if_flush_pc_out(if_flush_pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request at pc is outstanding; return data next cycle with no BTB hit expected.
    task automatic do_fetch(input logic [15:0] pc, input logic [15:0] data);
        logic [15:0] fall;
        fall = pc + 16'd2;
        chk("req_read", icache_read, 1'b1);
        chk("req_addr", icache_addr, pc);
        chk("req_noload", load_if_id, 1'b0);
        tick();
        icache_resp = 1'b1; icache_rdata = data;
        #1;
        chk("resp_load", load_if_id, 1'b1);
        chk("resp_stall", i_cache_stall, 1'b0);
        chk("resp_pc", if_pc_out, pc);
        chk("resp_ir", if_ir_out, data);
        chk("resp_flush", if_flush_pc_out, fall);
        chk("resp_nohit", if_btb_hit_out, 1'b0);
        tick();
        icache_resp = 1'b0; icache_rdata = 16'h0000;
        #1;
    endtask

    task automatic fetch_pred(input logic [15:0] pc, input logic hit, input logic taken,
                              input logic [15:0] tgt);
        chk("pred_addr", icache_addr, pc);
        tick();
        icache_resp = 1'b1; icache_rdata = 16'h0C00;
        #1;
        chk("pred_load", load_if_id, 1'b1);
        chk("pred_hit", if_btb_hit_out, hit);
        chk("pred_taken", if_pred_taken_out, taken);
        chk("pred_target", if_btb_target_out, tgt);
        tick();
        icache_resp = 1'b0;
        #1;
        chk("pred_next_addr", icache_addr, taken ? tgt : pc + 16'd2);
    endtask

    // From FETCH with a read outstanding: redirect, then let the stale read finish.
    task automatic redirect_to(input logic [15:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        #1;
        chk("redir_noload", load_if_id, 1'b0);
        tick();
        redirect_valid = 1'b0;
        icache_resp = 1'b1; icache_rdata = 16'hDEAD;
        #1;
        chk("drop_noload", load_if_id, 1'b0);
        tick();
        icache_resp = 1'b0;
        #1;
    endtask

    task automatic btb_update(input logic [15:0] pc, input logic [15:0] tgt, input logic taken);
        btb_upd_valid = 1'b1; btb_upd_pc = pc; btb_upd_target = tgt; btb_upd_taken = taken;
        tick();
        btb_upd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pipe_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        btb_upd_valid = 1'b0; btb_upd_pc = 16'h0; btb_upd_target = 16'h0; btb_upd_taken = 1'b0;
        icache_resp = 1'b0; icache_rdata = 16'h0;

        // Reset behaviour, including a reset asserted mid-FETCH
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_release_noread", icache_read, 1'b0);
        tick();
        chk("first_read", icache_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_read", icache_read, 1'b0);
        chk("rst_stall", i_cache_stall, 1'b1);
        chk("rst_load", load_if_id, 1'b0);
        chk("rst_addr", icache_addr, 16'h0000);
        chk("rst_pc", if_pc_out, 16'h0000);
        chk("rst_ir", if_ir_out, 16'h0000);
        chk("rst_flush", if_flush_pc_out, 16'h0000);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2_noread", icache_read, 1'b0);
        tick();

        // Straight-line fetch
        do_fetch(16'h0000, 16'h1000);
        do_fetch(16'h0002, 16'h1001);
        do_fetch(16'h0004, 16'h1002);
        do_fetch(16'h0006, 16'h1003);

        // Stall while a response arrives: hold for 3 cycles
        chk("hold_req_addr", icache_addr, 16'h0008);
        tick();
        pipe_stall = 1'b1; icache_resp = 1'b1; icache_rdata = 16'hABCD;
        #1;
        chk("stall_resp_noload", load_if_id, 1'b0);
        tick();
        icache_resp = 1'b0; icache_rdata = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_noread", icache_read, 1'b0);
            chk("hold_pc", if_pc_out, 16'h0008);
            chk("hold_ir", if_ir_out, 16'hABCD);
            chk("hold_noload", load_if_id, 1'b0);
            tick();
        end
        pipe_stall = 1'b0;
        #1;
        chk("hold_release_load", load_if_id, 1'b1);
        chk("hold_release_pc", if_pc_out, 16'h0008);
        chk("hold_release_flush", if_flush_pc_out, 16'h000A);
        tick();
        chk("after_hold_noload", load_if_id, 1'b0);

        // Redirect while a read to 0x0010 is pending
        do_fetch(16'h000A, 16'h2000);
        do_fetch(16'h000C, 16'h2001);
        do_fetch(16'h000E, 16'h2002);
        chk("pend_addr", icache_addr, 16'h0010);
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        #1;
        chk("redir_noload", load_if_id, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("drop_read", icache_read, 1'b1);
        chk("drop_addr1", icache_addr, 16'h0010);
        tick();
        chk("drop_addr2", icache_addr, 16'h0010);
        icache_resp = 1'b1; icache_rdata = 16'hDEAD;
        #1;
        chk("drop_noload", load_if_id, 1'b0);
        chk("drop_stall", i_cache_stall, 1'b1);
        tick();
        icache_resp = 1'b0;
        #1;
        chk("post_redir_addr", icache_addr, 16'h0040);

        // BTB: two taken updates for 0x0008 -> 0x0020
        btb_update(16'h0008, 16'h0020, 1'b1);
        btb_update(16'h0008, 16'h0020, 1'b1);
        #1;
        do_fetch(16'h0040, 16'h3000);
        redirect_to(16'h0008);
        fetch_pred(16'h0008, 1'b1, 1'b1, 16'h0020);

        // Saturation: taken (stays 11), not-taken (10) still taken, not-taken (01) not taken
        btb_update(16'h0008, 16'h0020, 1'b1);
        btb_update(16'h0008, 16'h0020, 1'b0);
        #1;
        redirect_to(16'h0008);
        fetch_pred(16'h0008, 1'b1, 1'b1, 16'h0020);
        btb_update(16'h0008, 16'h0020, 1'b0);
        #1;
        redirect_to(16'h0008);
        fetch_pred(16'h0008, 1'b1, 1'b0, 16'h0020);

        // Fall-through wraps at the top of the address space
        redirect_to(16'hFFFE);
        do_fetch(16'hFFFE, 16'h4000);
        chk("wrap_addr", icache_addr, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
